// File: rtl/clk_ratio_monitor.sv
// Measures the period of an asynchronous divided clock in clk cycles and reports lock, error and stall.
// Optional duty-cycle check is compiled in with `define DUTY_CHECK_EN.
module clk_ratio_monitor #(
  parameter int CNT_W     = 16,
  parameter int EXP_RATIO = 4,
  parameter int TOL       = 0,
  parameter int LOCK_CNT  = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             mon_clk,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err,
  output logic             stall,
  output logic             duty_err
);
  localparam int RUN_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_MEAS, ST_LOCKED} state_t;
  state_t state, state_n;

  logic             s1, s2, s3;
  logic             rise, timeout, in_tol;
  logic [CNT_W-1:0] cnt;
  logic [RUN_W-1:0] run_cnt, run_inc;
  logic [CNT_W:0]   meas_p, exp_r, diff;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) {s1, s2, s3} <= 3'b000;
    else         {s1, s2, s3} <= {mon_clk, s1, s2};
  end

  assign rise    = s2 & ~s3;
  // one bit wider than the counter so cnt+1 and the difference never wrap
  assign meas_p  = {1'b0, cnt} + (CNT_W+1)'(1);
  assign exp_r   = (CNT_W+1)'(EXP_RATIO);
  assign diff    = (meas_p >= exp_r) ? (meas_p - exp_r) : (exp_r - meas_p);
  assign in_tol  = diff <= (CNT_W+1)'(TOL);
  assign timeout = (state != ST_IDLE) && !rise && (cnt == TMO);
  assign run_inc = (run_cnt == RUN_W'(LOCK_CNT)) ? run_cnt : run_cnt + RUN_W'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (rise) state_n = ST_MEAS;
      default: begin
        if (rise) begin
          if (!in_tol)                          state_n = ST_MEAS;
          else if (run_inc == RUN_W'(LOCK_CNT)) state_n = ST_LOCKED;
        end else if (timeout) begin
          state_n = ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    locked = (state == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt          <= '0;
      run_cnt      <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      err          <= 1'b0;
      stall        <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      err          <= 1'b0;
      if (state == ST_IDLE) begin
        // first edge only restarts the measurement
        if (rise) begin
          cnt     <= '0;
          run_cnt <= '0;
          stall   <= 1'b0;
        end
      end else if (rise) begin
        cnt          <= '0;
        period       <= meas_p[CNT_W-1:0];
        period_valid <= 1'b1;
        if (in_tol) run_cnt <= run_inc;
        else begin
          run_cnt <= '0;
          err     <= 1'b1;
        end
      end else if (timeout) begin
        err     <= 1'b1;
        stall   <= 1'b1;
        run_cnt <= '0;
      end else if (cnt != TMO) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef DUTY_CHECK_EN
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W:0]   high, half, hdiff;

  // the rise cycle itself counts as the last high cycle of the period
  assign high  = {1'b0, hcnt} + {{CNT_W{1'b0}}, s2};
  assign half  = meas_p >> 1;
  assign hdiff = (high >= half) ? (high - half) : (half - high);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hcnt     <= '0;
      duty_err <= 1'b0;
    end else begin
      duty_err <= 1'b0;
      if (rise) begin
        hcnt     <= '0;
        duty_err <= (state != ST_IDLE) && (hdiff > (CNT_W+1)'(TOL));
      end else if ((state != ST_IDLE) && s2 && (hcnt != TMO)) begin
        hcnt <= hcnt + CNT_W'(1);
      end
    end
  end
`else
  assign duty_err = 1'b0;
`endif

endmodule
